// File: rtl/cmul_arb.sv
// Round-robin arbiter/sequencer sharing one sequential 8-bit complex multiplier among NREQ requesters.
// Define CMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index always wins).
module cmul_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [8*NREQ-1:0] req_a_r,
    input  logic [8*NREQ-1:0] req_a_i,
    input  logic [8*NREQ-1:0] req_b_r,
    input  logic [8*NREQ-1:0] req_b_i,
    output logic              mul_en,
    output logic [7:0]        mul_a_r,
    output logic [7:0]        mul_a_i,
    output logic [7:0]        mul_b_r,
    output logic [7:0]        mul_b_i,
    input  logic [16:0]       mul_o_r,
    input  logic [16:0]       mul_o_i,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [IDW-1:0]    rsp_id,
    output logic [16:0]       rsp_r,
    output logic [16:0]       rsp_i
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
`ifndef CMUL_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  rr_ptr;
`endif

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_id;
    logic            found;
    logic [7:0]      sel_a_r, sel_a_i, sel_b_r, sel_b_i;
    int unsigned     start;

    // Two passes: indices at/above the pointer first, then wrap around to the rest.
    always_comb begin
        grant   = '0;
        win_id  = '0;
        found   = 1'b0;
        sel_a_r = '0;
        sel_a_i = '0;
        sel_b_r = '0;
        sel_b_i = '0;
`ifdef CMUL_ARB_FIXED_PRIO_EN
        start   = '0;
`else
        start   = 32'(rr_ptr);
`endif
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!found && req_vld[k] && (pass == 1 || k >= start)) begin
                    found    = 1'b1;
                    grant[k] = 1'b1;
                    win_id   = IDW'(k);
                    sel_a_r  = req_a_r[8*k +: 8];
                    sel_a_i  = req_a_i[8*k +: 8];
                    sel_b_r  = req_b_r[8*k +: 8];
                    sel_b_i  = req_b_i[8*k +: 8];
                end
            end
        end
    end

    assign req_rdy = (state == S_IDLE && !rst) ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
`ifndef CMUL_ARB_FIXED_PRIO_EN
            rr_ptr  <= '0;
`endif
            mul_en  <= 1'b0;
            mul_a_r <= '0;
            mul_a_i <= '0;
            mul_b_r <= '0;
            mul_b_i <= '0;
            rsp_vld <= 1'b0;
            rsp_id  <= '0;
            rsp_r   <= '0;
            rsp_i   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mul_a_r <= sel_a_r;
                        mul_a_i <= sel_a_i;
                        mul_b_r <= sel_b_r;
                        mul_b_i <= sel_b_i;
                        rsp_id  <= win_id;
`ifndef CMUL_ARB_FIXED_PRIO_EN
                        rr_ptr  <= (32'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
`endif
                        mul_en  <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_en <= 1'b0;
                    cnt    <= CW'(LAT - 1);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rsp_r   <= mul_o_r;
                        rsp_i   <= mul_o_i;
                        rsp_vld <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmul_arb.sv
// Self-checking bench for cmul_arb: behavioural LAT-cycle multiplier, spec-level arbitration model.
module tb_cmul_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 5;

    logic              clk, rst;
    logic [NREQ-1:0]   req_vld, req_rdy;
    logic [8*NREQ-1:0] req_a_r, req_a_i, req_b_r, req_b_i;
    logic              mul_en;
    logic [7:0]        mul_a_r, mul_a_i, mul_b_r, mul_b_i;
    logic [16:0]       mul_o_r, mul_o_i;
    logic              rsp_vld, rsp_rdy;
    logic [IDW-1:0]    rsp_id;
    logic [16:0]       rsp_r, rsp_i;

    cmul_arb #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a_r(req_a_r), .req_a_i(req_a_i), .req_b_r(req_b_r), .req_b_i(req_b_i),
        .mul_en(mul_en),
        .mul_a_r(mul_a_r), .mul_a_i(mul_a_i), .mul_b_r(mul_b_r), .mul_b_i(mul_b_i),
        .mul_o_r(mul_o_r), .mul_o_i(mul_o_i),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_i(rsp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] cr(input int ar, input int ai, input int br, input int bi);
        return 17'(ar * br - ai * bi);
    endfunction

    function automatic logic [16:0] ci(input int ar, input int ai, input int br, input int bi);
        return 17'(ar * bi + ai * br);
    endfunction

    // Multiplier: result valid only LAT edges after the edge sampling mul_en, junk otherwise.
    logic [LAT-1:0] pv;
    logic [16:0]    junk_r, junk_i;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv     <= '0;
            junk_r <= '0;
            junk_i <= '0;
        end else begin
            pv     <= {pv[LAT-2:0], mul_en};
            junk_r <= 17'($urandom);
            junk_i <= 17'($urandom);
        end
    end
    assign mul_o_r = pv[LAT-1] ? cr($signed(mul_a_r), $signed(mul_a_i), $signed(mul_b_r), $signed(mul_b_i)) : junk_r;
    assign mul_o_i = pv[LAT-1] ? ci($signed(mul_a_r), $signed(mul_a_i), $signed(mul_b_r), $signed(mul_b_i)) : junk_i;

    int n_chk = 0;
    int n_fail = 0;
    int ar[NREQ], ai[NREQ], br[NREQ], bi[NREQ];
    int ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
`ifdef CMUL_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < NREQ; k++) begin
            ar[k] = int'($urandom_range(255)) - 128;
            ai[k] = int'($urandom_range(255)) - 128;
            br[k] = int'($urandom_range(255)) - 128;
            bi[k] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic drive_ops();
        for (int k = 0; k < NREQ; k++) begin
            req_a_r[8*k +: 8] = 8'(ar[k]);
            req_a_i[8*k +: 8] = 8'(ai[k]);
            req_b_r[8*k +: 8] = 8'(br[k]);
            req_b_i[8*k +: 8] = 8'(bi[k]);
        end
    endtask

    // One transaction for requester id, with bp cycles of response backpressure.
    task automatic do_txn(input int id, input int bp, input bit keep);
        int n;
        logic [16:0] er, ei;
        logic [31:0] eop;
        #1;
        n = 0;
        while (req_rdy == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(req_rdy), 32'(1 << id));
        er  = cr(ar[id], ai[id], br[id], bi[id]);
        ei  = ci(ar[id], ai[id], br[id], bi[id]);
        eop = {8'(ar[id]), 8'(ai[id]), 8'(br[id]), 8'(bi[id])};
        ptr = (id + 1) % NREQ;
        @(negedge clk);
        if (!keep) req_vld[id] = 1'b0;
        chk("mul_en_rise", 32'(mul_en), 32'd1);
        chk("rdy_pulse", 32'(req_rdy), 32'd0);
        chk("mul_ops", {mul_a_r, mul_a_i, mul_b_r, mul_b_i}, eop);
        n = 0;
        while (!rsp_vld && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("mul_en_fall", 32'(mul_en), 32'd0);
        end
        chk("latency", 32'(n), 32'(LAT + 1));
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_r", 32'(rsp_r), 32'(er));
        chk("rsp_i", 32'(rsp_i), 32'(ei));
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk("bp_vld", 32'(rsp_vld), 32'd1);
            chk("bp_r", 32'(rsp_r), 32'(er));
            chk("bp_id_i", 32'({rsp_id, rsp_i}), 32'({IDW'(id), ei}));
            chk("bp_rdy", 32'(req_rdy), 32'd0);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        chk("rsp_clear", 32'(rsp_vld), 32'd0);
    endtask

    // Continuous traffic with rsp_rdy high and fresh random operands every cycle.
    task automatic stream(input logic [NREQ-1:0] mask, input int ngr);
        int last, g, r, e;
        logic [16:0] q_r[$], q_i[$];
        int q_id[$];
        last = -1; g = 0; r = 0;
        rsp_rdy = 1'b1;
        for (int c = 0; c < ngr * (LAT + 3) + 20 && r < ngr; c++) begin
            @(negedge clk);
            req_vld = (g < ngr) ? mask : '0;
            rand_ops();
            drive_ops();
            #1;
            if (req_rdy != '0) begin
                e = winner(mask, ptr);
                chk("s_grant", 32'(req_rdy), 32'(1 << e));
                if (last >= 0) chk("s_spacing", 32'(c - last), 32'(LAT + 3));
                last = c;
                ptr = (e + 1) % NREQ;
                q_id.push_back(e);
                q_r.push_back(cr(ar[e], ai[e], br[e], bi[e]));
                q_i.push_back(ci(ar[e], ai[e], br[e], bi[e]));
                g++;
            end
            if (rsp_vld) begin
                chk("s_qdepth", 32'(q_id.size() > 0), 32'd1);
                if (q_id.size() > 0) begin
                    chk("s_id", 32'(rsp_id), 32'(q_id.pop_front()));
                    chk("s_r", 32'(rsp_r), 32'(q_r.pop_front()));
                    chk("s_i", 32'(rsp_i), 32'(q_i.pop_front()));
                end
                r++;
            end
        end
        chk("s_grants", 32'(g), 32'(ngr));
        chk("s_resps", 32'(r), 32'(ngr));
        @(negedge clk);
        rsp_rdy = 1'b0;
        req_vld = '0;
    endtask

    initial begin
        int n, seen;
        rst = 1'b0;
        req_vld = '1;
        rsp_rdy = 1'b0;
        rand_ops();
        drive_ops();
        #2 rst = 1'b1;
        #1;
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_mul_en", 32'(mul_en), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp", 32'({rsp_id, rsp_r[12:0]}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req_vld = '0;
        ptr = 0;

        // Single request on requester 2: (3+4j)*(2-j) = 10+5j
        @(negedge clk);
        ar[2] = 3; ai[2] = 4; br[2] = 2; bi[2] = -1;
        drive_ops();
        req_vld = 4'b0100;
        do_txn(2, 0, 1'b0);

        // Extreme operands: product imag part needs the full 17 bits
        ar[3] = -128; ai[3] = -128; br[3] = -128; bi[3] = -128;
        drive_ops();
        req_vld = 4'b1000;
        do_txn(3, 0, 1'b0);

        // Backpressure with requester 1 pending
        rand_ops();
        drive_ops();
        req_vld = 4'b0011;
        do_txn(0, 10, 1'b0);
        #1;
        chk("bp_next_grant", 32'(req_rdy), 32'b0010);
        do_txn(1, 0, 1'b0);

        // Reset two cycles after mul_en
        rand_ops();
        drive_ops();
        req_vld = 4'b0100;
        #1;
        n = 0;
        while (req_rdy == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mw_grant", 32'(req_rdy), 32'(1 << winner(4'b0100, ptr)));
        @(negedge clk);
        req_vld = '0;
        chk("mw_mul_en", 32'(mul_en), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_vld = '1;
        #1;
        chk("mw_mul_en0", 32'(mul_en), 32'd0);
        chk("mw_ops0", {mul_a_r, mul_a_i, mul_b_r, mul_b_i}, 32'd0);
        chk("mw_rsp_vld0", 32'(rsp_vld), 32'd0);
        chk("mw_rsp_r0", 32'(rsp_r), 32'd0);
        chk("mw_rsp_i_id0", 32'({rsp_id, rsp_i}), 32'd0);
        chk("mw_rdy0", 32'(req_rdy), 32'd0);
        ptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_vld = '0;
        seen = 0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (rsp_vld) seen++;
        end
        chk("mw_no_rsp", 32'(seen), 32'd0);
        rand_ops();
        drive_ops();
        req_vld = 4'b1001;
        do_txn(0, 0, 1'b0);
        do_txn(3, 0, 1'b0);

        // Streams: all four requesters, then requesters 0 and 3 only
        stream(4'b1111, 8);
        stream(4'b1001, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
